// File: rtl/issue_sb_pkg.sv
// Shared types and defaults for the issue scoreboard.
package issue_sb_pkg;

  localparam int unsigned SB_CNT_BITS = 2;

  typedef enum logic [1:0] {SB_RUN, SB_DRAIN, SB_HALT} sb_state_t;

endpackage

// File: rtl/sb_counter_bank.sv
// Per-register in-flight write counters for one register file.
// With SCOREBOARD_BYPASS_EN, a register whose last pending write retires this cycle reads as not busy.
module sb_counter_bank
  import issue_sb_pkg::*;
#(
  parameter int unsigned IDX_BITS = 4,
  parameter int unsigned CNT_BITS = SB_CNT_BITS,
  localparam int unsigned NREG = 2 ** IDX_BITS
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                inc_en,
  input  logic [IDX_BITS-1:0] inc_idx,
  input  logic                dec_en,
  input  logic [IDX_BITS-1:0] dec_idx,
  output logic [NREG-1:0]     busy,
  output logic [NREG-1:0]     sat,
  output logic                all_zero,
  output logic                underflow
);

  localparam logic [CNT_BITS-1:0] CNT_MAX = '1;

  logic [CNT_BITS-1:0] cnt_q [NREG];
  logic [NREG-1:0]     inc_hit;
  logic [NREG-1:0]     dec_hit;

  // Retires against an empty counter are dropped and only reported.
  always_comb begin
    inc_hit  = '0;
    dec_hit  = '0;
    busy     = '0;
    sat      = '0;
    all_zero = 1'b1;
    for (int unsigned i = 0; i < NREG; i++) begin
      inc_hit[i] = inc_en && (inc_idx == IDX_BITS'(i));
      dec_hit[i] = dec_en && (dec_idx == IDX_BITS'(i)) && (cnt_q[i] != '0);
      busy[i]    = (cnt_q[i] != '0);
      sat[i]     = (cnt_q[i] == CNT_MAX);
`ifdef SCOREBOARD_BYPASS_EN
      if ((cnt_q[i] == CNT_BITS'(1)) && dec_hit[i]) begin
        busy[i] = 1'b0;
      end
`endif
      if (cnt_q[i] != '0) begin
        all_zero = 1'b0;
      end
    end
    underflow = dec_en && (cnt_q[dec_idx] == '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < NREG; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < NREG; i++) begin
        if (inc_hit[i] && !dec_hit[i]) begin
          cnt_q[i] <= cnt_q[i] + CNT_BITS'(1);
        end else if (dec_hit[i] && !inc_hit[i]) begin
          cnt_q[i] <= cnt_q[i] - CNT_BITS'(1);
        end
      end
    end
  end

endmodule

// File: rtl/issue_scoreboard.sv
// Issue controller: RAW/saturation stalls on scalar and vector files, END drain and halt.
// Optional SCOREBOARD_BYPASS_EN lets a dependant issue in the cycle its last pending write retires.
module issue_scoreboard
  import issue_sb_pkg::*;
#(
  parameter int unsigned REGI_BITS = 4,
  parameter int unsigned VECT_BITS = 2,
  parameter int unsigned CNT_BITS  = SB_CNT_BITS
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 dec_valid_i,
  input  logic [REGI_BITS-1:0] dec_int_src1_i,
  input  logic [REGI_BITS-1:0] dec_int_src2_i,
  input  logic                 dec_use_int1_i,
  input  logic                 dec_use_int2_i,
  input  logic [VECT_BITS-1:0] dec_vec_src1_i,
  input  logic [VECT_BITS-1:0] dec_vec_src2_i,
  input  logic                 dec_use_vec1_i,
  input  logic                 dec_use_vec2_i,
  input  logic [REGI_BITS-1:0] dec_int_dest_i,
  input  logic                 dec_wr_int_i,
  input  logic [VECT_BITS-1:0] dec_vec_dest_i,
  input  logic                 dec_wr_vec_i,
  input  logic                 dec_end_i,
  input  logic                 flush_i,
  input  logic                 wb_int_we_i,
  input  logic [REGI_BITS-1:0] wb_int_dest_i,
  input  logic                 wb_vec_we_i,
  input  logic [VECT_BITS-1:0] wb_vec_dest_i,
  output logic                 stall_o,
  output logic                 issue_o,
  output logic                 halted_o,
  output logic                 underflow_o
);

  localparam int unsigned NINT = 2 ** REGI_BITS;
  localparam int unsigned NVEC = 2 ** VECT_BITS;

  sb_state_t       state_q, state_d;
  logic            halted_q, underflow_q;
  logic [NINT-1:0] int_busy, int_sat;
  logic [NVEC-1:0] vec_busy, vec_sat;
  logic            int_zero, vec_zero, int_uf, vec_uf;
  logic            hazard;

  sb_counter_bank #(.IDX_BITS(REGI_BITS), .CNT_BITS(CNT_BITS)) u_int_bank (
    .clk       (clk),
    .rst       (rst),
    .inc_en    (issue_o && dec_wr_int_i),
    .inc_idx   (dec_int_dest_i),
    .dec_en    (wb_int_we_i),
    .dec_idx   (wb_int_dest_i),
    .busy      (int_busy),
    .sat       (int_sat),
    .all_zero  (int_zero),
    .underflow (int_uf)
  );

  sb_counter_bank #(.IDX_BITS(VECT_BITS), .CNT_BITS(CNT_BITS)) u_vec_bank (
    .clk       (clk),
    .rst       (rst),
    .inc_en    (issue_o && dec_wr_vec_i),
    .inc_idx   (dec_vec_dest_i),
    .dec_en    (wb_vec_we_i),
    .dec_idx   (wb_vec_dest_i),
    .busy      (vec_busy),
    .sat       (vec_sat),
    .all_zero  (vec_zero),
    .underflow (vec_uf)
  );

  assign hazard = (dec_use_int1_i && int_busy[dec_int_src1_i])
               || (dec_use_int2_i && int_busy[dec_int_src2_i])
               || (dec_use_vec1_i && vec_busy[dec_vec_src1_i])
               || (dec_use_vec2_i && vec_busy[dec_vec_src2_i])
               || (dec_wr_int_i   && int_sat[dec_int_dest_i])
               || (dec_wr_vec_i   && vec_sat[dec_vec_dest_i]);

  always_comb begin
    state_d = state_q;
    stall_o = 1'b1;
    issue_o = 1'b0;
    case (state_q)
      SB_RUN: begin
        stall_o = rst || hazard;
        issue_o = dec_valid_i && !stall_o && !flush_i;
        if (issue_o && dec_end_i) begin
          state_d = SB_DRAIN;
        end
      end
      SB_DRAIN: begin
        if (int_zero && vec_zero && !wb_int_we_i && !wb_vec_we_i) begin
          state_d = SB_HALT;
        end
      end
      SB_HALT: state_d = SB_HALT;
      default: state_d = SB_RUN;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= SB_RUN;
      halted_q    <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      halted_q    <= (state_d == SB_HALT);
      underflow_q <= underflow_q || int_uf || vec_uf;
    end
  end

  assign halted_o    = halted_q;
  assign underflow_o = underflow_q;

endmodule
